// File: rtl/ddr3_bram_backend.sv
// On-chip memory slave for the ddr3_axi_ctrl memory port: byte-masked burst writes,
// fixed-length burst reads through a 2-entry skid buffer, in-band error pulse.
module ddr3_bram_backend #(
  parameter int WIDTH = 32,
  parameter int MASKS = WIDTH / 8,
  parameter int ADDRS = 32,
  parameter int REQID = 4,
  parameter int MBITS = 10,
  parameter int BURST = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mem_store_i,
  input  logic             mem_fetch_i,
  output logic             mem_accept_o,
  output logic             mem_error_o,
  input  logic [REQID-1:0] mem_req_id_i,
  input  logic [ADDRS-1:0] mem_addr_i,
  input  logic             mem_valid_i,
  output logic             mem_ready_o,
  input  logic             mem_last_i,
  input  logic [MASKS-1:0] mem_wrmask_i,
  input  logic [WIDTH-1:0] mem_wrdata_i,
  output logic             mem_valid_o,
  input  logic             mem_ready_i,
  output logic             mem_last_o,
  output logic [REQID-1:0] mem_resp_id_o,
  output logic [WIDTH-1:0] mem_rddata_o
);

  localparam int LSB = $clog2(MASKS);
  localparam int IW  = $clog2(BURST + 1);
  localparam int BW  = $clog2(BURST);
  localparam logic [IW-1:0]    ISSUE_ALL = IW'(BURST);
  localparam logic [BW-1:0]    LAST_BEAT = BW'(BURST - 1);
  localparam logic [ADDRS-1:0] LOW_MASK  = ADDRS'((64'd1 << LSB) - 64'd1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  state_t r_state, w_next;

  logic [WIDTH-1:0] r_mem [0:(1<<MBITS)-1];
  logic [WIDTH-1:0] r_rd_q;
  logic [WIDTH-1:0] r_skid [2];

  logic             r_accept;
  logic             r_error;
  logic [REQID-1:0] r_resp_id;
  logic [MBITS-1:0] r_waddr;
  logic             r_werr;
  logic [MBITS-1:0] r_raddr;
  logic             r_rerr;
  logic [IW-1:0]    r_issued;
  logic             r_inflight;
  logic [BW-1:0]    r_beat;
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;

  logic             w_hs;
  logic             w_store_hs;
  logic             w_fetch_hs;
  logic             w_bad;
  logic [MBITS-1:0] w_widx;
  logic             w_ready;
  logic             w_wbeat;
  logic             w_valid;
  logic             w_pop;
  logic [1:0]       w_occ;
  logic             w_issue_rd;
  logic             w_rd_en;
  logic [MBITS-1:0] w_rd_addr;

  assign w_hs       = (mem_store_i | mem_fetch_i) & r_accept;
  assign w_store_hs = w_hs & mem_store_i;
  assign w_fetch_hs = w_hs & ~mem_store_i & mem_fetch_i;
  assign w_widx     = mem_addr_i[MBITS+LSB-1:LSB];
  assign w_bad      = ((mem_addr_i & LOW_MASK) != '0) || ((mem_addr_i >> (MBITS + LSB)) != '0);

  assign w_wbeat    = w_ready & mem_valid_i;
  assign w_valid    = (r_count != 2'd0);
  assign w_pop      = w_valid & mem_ready_i;

  // Reads are throttled on post-pop occupancy so a stream under ready=1 runs gap-free
  // while the two skid entries still absorb every beat already in flight.
  assign w_occ      = r_count - {1'b0, w_pop};
  assign w_issue_rd = (r_state == S_READ) && ((w_occ + {1'b0, r_inflight}) < 2'd2) &&
                      (r_issued != ISSUE_ALL);
  assign w_rd_en    = w_fetch_hs | w_issue_rd;
  assign w_rd_addr  = (r_state == S_IDLE) ? w_widx : r_raddr;

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_store_hs)      w_next = S_WRITE;
        else if (w_fetch_hs) w_next = S_READ;
      end
      S_WRITE: begin
        w_ready = 1'b1;
        if (mem_valid_i && mem_last_i) w_next = S_IDLE;
      end
      S_READ: begin
        if (w_pop && (r_beat == LAST_BEAT)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_rd_en) r_rd_q <= r_mem[w_rd_addr];
    if (w_wbeat && !r_werr) begin
      for (int unsigned i = 0; i < MASKS; i++) begin
        if (mem_wrmask_i[i]) r_mem[r_waddr][8*i +: 8] <= mem_wrdata_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_accept   <= 1'b0;
      r_error    <= 1'b0;
      r_resp_id  <= '0;
      r_waddr    <= '0;
      r_werr     <= 1'b0;
      r_raddr    <= '0;
      r_rerr     <= 1'b0;
      r_issued   <= '0;
      r_inflight <= 1'b0;
      r_beat     <= '0;
      r_skid[0]  <= '0;
      r_skid[1]  <= '0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      r_state  <= w_next;
      r_accept <= (w_next == S_IDLE);
      r_error  <= w_hs & w_bad;

      if (w_store_hs) begin
        r_waddr <= w_widx;
        r_werr  <= w_bad;
      end else if (w_wbeat) begin
        r_waddr <= r_waddr + 1'b1;
      end

      // The first word is read on the accept edge itself, so beat 1 lands two cycles on.
      if (w_fetch_hs) begin
        r_resp_id <= mem_req_id_i;
        r_rerr    <= w_bad;
        r_raddr   <= w_widx + 1'b1;
        r_issued  <= IW'(1);
      end else if (w_issue_rd) begin
        r_raddr  <= r_raddr + 1'b1;
        r_issued <= r_issued + 1'b1;
      end
      r_inflight <= w_rd_en;

      if (r_inflight) begin
        r_skid[r_wptr] <= r_rerr ? '0 : r_rd_q;
        r_wptr         <= ~r_wptr;
      end

      if (w_fetch_hs) begin
        r_beat <= '0;
      end else if (w_pop) begin
        r_beat <= r_beat + 1'b1;
      end
      if (w_pop) r_rptr <= ~r_rptr;

      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  assign mem_accept_o  = r_accept;
  assign mem_error_o   = r_error;
  assign mem_ready_o   = w_ready;
  assign mem_valid_o   = w_valid;
  assign mem_last_o    = w_valid & (r_beat == LAST_BEAT);
  assign mem_resp_id_o = r_resp_id;
  assign mem_rddata_o  = r_skid[r_rptr];

endmodule

// File: tb/tb_ddr3_bram_backend.sv
// Scoreboarded bench for ddr3_bram_backend: expected read beats are queued when a
// fetch is issued and checked against the beats the backend hands back.
module tb_ddr3_bram_backend;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_store_i = 1'b0;
  logic        mem_fetch_i = 1'b0;
  logic        mem_accept_o;
  logic        mem_error_o;
  logic [3:0]  mem_req_id_i = 4'h0;
  logic [31:0] mem_addr_i = 32'h0;
  logic        mem_valid_i = 1'b0;
  logic        mem_ready_o;
  logic        mem_last_i = 1'b0;
  logic [3:0]  mem_wrmask_i = 4'h0;
  logic [31:0] mem_wrdata_i = 32'h0;
  logic        mem_valid_o;
  logic        mem_ready_i = 1'b0;
  logic        mem_last_o;
  logic [3:0]  mem_resp_id_o;
  logic [31:0] mem_rddata_o;

  ddr3_bram_backend #(
    .WIDTH(32),
    .ADDRS(32),
    .REQID(4),
    .MBITS(10),
    .BURST(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mem_store_i(mem_store_i),
    .mem_fetch_i(mem_fetch_i),
    .mem_accept_o(mem_accept_o),
    .mem_error_o(mem_error_o),
    .mem_req_id_i(mem_req_id_i),
    .mem_addr_i(mem_addr_i),
    .mem_valid_i(mem_valid_i),
    .mem_ready_o(mem_ready_o),
    .mem_last_i(mem_last_i),
    .mem_wrmask_i(mem_wrmask_i),
    .mem_wrdata_i(mem_wrdata_i),
    .mem_valid_o(mem_valid_o),
    .mem_ready_i(mem_ready_i),
    .mem_last_o(mem_last_o),
    .mem_resp_id_o(mem_resp_id_o),
    .mem_rddata_o(mem_rddata_o)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [3:0]  id;
    logic        known;
  } exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [3:0]  id;
    int          cyc;
  } obs_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] model [1024];
  bit          known [1024];
  exp_t        exp_q[$];
  obs_t        obs_q[$];
  int          err_q[$];
  int          stab_n = 0;
  int          stab_bad = 0;
  logic [31:0] bp = 32'hAAAAAAA9;  // ready pattern 1,0,0,1,0,1 then alternating

  always @(posedge clock) cyc++;
  always @(negedge clock) if (mem_error_o === 1'b1) err_q.push_back(cyc);

  task automatic do_store(input logic [31:0] a, input int n, input logic [31:0] d0,
                          input logic [31:0] step, input logic [3:0] m,
                          output int hs_cyc, output int end_cyc);
    bit bad, hs, rdy;
    int g;
    int unsigned w;
    logic [31:0] d;
    bad = (a[1:0] != 2'b0) || ((a >> 12) != 32'h0);
    w = a[11:2];
    mem_store_i = 1'b1; mem_addr_i = a; mem_req_id_i = 4'h0;
    hs = 1'b0; g = 0;
    while (!hs && g < 100) begin
      @(negedge clock); hs = mem_accept_o;
      @(posedge clock); #1; g++;
    end
    mem_store_i = 1'b0;
    hs_cyc = cyc;
    if (!hs) begin checks++; errors++; $display("FAIL store_accept_timeout addr=%h", a); end
    for (int i = 0; i < n && hs; i++) begin
      d = d0 + step * i;
      mem_valid_i = 1'b1; mem_last_i = (i == n - 1); mem_wrdata_i = d; mem_wrmask_i = m;
      rdy = 1'b0; g = 0;
      while (!rdy && g < 20) begin
        @(negedge clock); rdy = mem_ready_o;
        @(posedge clock); #1; g++;
      end
      if (!rdy) begin checks++; errors++; $display("FAIL store_beat_timeout beat=%0d", i); break; end
      if (!bad) begin
        for (int b = 0; b < 4; b++) if (m[b]) model[w][8*b +: 8] = d[8*b +: 8];
        known[w] = known[w] | (m == 4'hF);
      end
      w = (w + 1) % 1024;
    end
    mem_valid_i = 1'b0; mem_last_i = 1'b0;
    end_cyc = cyc;
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [3:0] id, input int mode,
                          output int hs_cyc, output int acc_cyc);
    bit bad, hs, done, pv, pr, pl;
    logic [31:0] pd;
    logic [3:0]  pid;
    int g, k;
    int unsigned w;
    bad = (a[1:0] != 2'b0) || ((a >> 12) != 32'h0);
    w = a[11:2];
    for (int unsigned i = 0; i < 4; i++) begin
      exp_q.push_back('{data: bad ? 32'h0 : model[(w + i) % 1024], last: (i == 3), id: id,
                        known: bad || known[(w + i) % 1024]});
    end
    mem_fetch_i = 1'b1; mem_addr_i = a; mem_req_id_i = id;
    hs = 1'b0; g = 0;
    while (!hs && g < 100) begin
      @(negedge clock); hs = mem_accept_o;
      @(posedge clock); #1; g++;
    end
    mem_fetch_i = 1'b0;
    hs_cyc = cyc;
    if (!hs) begin checks++; errors++; $display("FAIL fetch_accept_timeout addr=%h", a); end
    done = 1'b0; k = 0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; pid = '0;
    while (hs && !done && k < 100) begin
      mem_ready_i = (mode == 0) ? 1'b1 : bp[k % 32];
      @(negedge clock);
      if (pv && !pr) begin
        stab_n++;
        if (!(mem_valid_o === 1'b1 && mem_rddata_o === pd && mem_resp_id_o === pid &&
              mem_last_o === pl)) stab_bad++;
      end
      pv = mem_valid_o; pr = mem_ready_i; pd = mem_rddata_o; pid = mem_resp_id_o; pl = mem_last_o;
      if (mem_valid_o && mem_ready_i) begin
        obs_q.push_back('{data: mem_rddata_o, last: mem_last_o, id: mem_resp_id_o, cyc: cyc});
        if (mem_last_o) done = 1'b1;
      end
      @(posedge clock); #1; k++;
    end
    if (hs && !done) begin checks++; errors++; $display("FAIL fetch_beats_timeout addr=%h", a); end
    g = 0;
    while (!mem_accept_o && g < 20) begin @(posedge clock); #1; g++; end
    acc_cyc = cyc;
    mem_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({mem_accept_o, mem_error_o, mem_ready_o, mem_valid_o, mem_last_o, mem_resp_id_o,
         mem_rddata_o} !== 41'h0) begin
      errors++; $display("FAIL reset_outputs got acc=%b err=%b rdy=%b vld=%b want all 0",
                         mem_accept_o, mem_error_o, mem_ready_o, mem_valid_o);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (mem_accept_o !== 1'b0) begin errors++; $display("FAIL reset_accept_early got %b want 0", mem_accept_o); end
    @(posedge clock); #1;
    checks++;
    if (mem_accept_o !== 1'b1) begin errors++; $display("FAIL reset_accept_rise got %b want 1", mem_accept_o); end
  endtask

  task automatic test_aligned();
    int sh, se, fh, fa, n;
    exp_t e; obs_t o;
    err_q.delete();
    do_store(32'h0, 4, 32'h11111111, 32'h11111111, 4'hF, sh, se);
    do_fetch(32'h0, 4'h5, 0, fh, fa);
    n = obs_q.size();
    checks++;
    if (n != 4) begin errors++; $display("FAIL aligned_count got %0d want 4", n); end
    for (int i = 0; i < n && i < 4; i++) begin
      checks++;
      if (obs_q[i].cyc != fh + 1 + i) begin
        errors++; $display("FAIL aligned_timing beat=%0d got cyc %0d want %0d", i, obs_q[i].cyc, fh + 1 + i);
      end
    end
    checks++;
    if (fa != fh + 5) begin errors++; $display("FAIL aligned_reaccept got cyc %0d want %0d", fa, fh + 5); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.last !== e.last || o.id !== e.id || (e.known && o.data !== e.data)) begin
        errors++; $display("FAIL aligned_beat got %h/%b/%h want %h/%b/%h", o.data, o.last, o.id, e.data, e.last, e.id);
      end
    end
    exp_q.delete(); obs_q.delete();
    checks++;
    if (err_q.size() != 0) begin errors++; $display("FAIL aligned_no_error got %0d pulses want 0", err_q.size()); end
  endtask

  task automatic test_mask();
    int sh, se, fh, fa;
    exp_t e; obs_t o;
    do_store(32'h40, 1, 32'h0, 32'h0, 4'hF, sh, se);
    do_store(32'h40, 1, 32'hAABBCCDD, 32'h0, 4'h5, sh, se);
    do_fetch(32'h40, 4'h3, 0, fh, fa);
    checks++;
    if (obs_q.size() != 4) begin errors++; $display("FAIL mask_count got %0d want 4", obs_q.size()); end
    if (obs_q.size() > 0) begin
      checks++;
      if (obs_q[0].data !== 32'h00BB00DD) begin
        errors++; $display("FAIL mask_data got %h want 00bb00dd", obs_q[0].data);
      end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.last !== e.last || o.id !== e.id || (e.known && o.data !== e.data)) begin
        errors++; $display("FAIL mask_beat got %h/%b/%h want %h/%b/%h", o.data, o.last, o.id, e.data, e.last, e.id);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    int fh, fa;
    exp_t e; obs_t o;
    stab_n = 0; stab_bad = 0;
    do_fetch(32'h0, 4'hA, 1, fh, fa);
    checks++;
    if (obs_q.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", obs_q.size()); end
    checks++;
    if (stab_n == 0 || stab_bad != 0) begin
      errors++; $display("FAIL bp_stable got %0d unstable of %0d stalls want 0 of >0", stab_bad, stab_n);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.last !== e.last || o.id !== e.id || (e.known && o.data !== e.data)) begin
        errors++; $display("FAIL bp_beat got %h/%b/%h want %h/%b/%h", o.data, o.last, o.id, e.data, e.last, e.id);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_wrap();
    int sh, se, fh, fa;
    exp_t e; obs_t o;
    do_store(32'hFF8, 4, 32'hCAFE0001, 32'h00000101, 4'hF, sh, se);
    do_fetch(32'hFF8, 4'h7, 0, fh, fa);
    checks++;
    if (obs_q.size() != 4) begin errors++; $display("FAIL wrap_count got %0d want 4", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.last !== e.last || o.id !== e.id || (e.known && o.data !== e.data)) begin
        errors++; $display("FAIL wrap_beat got %h/%b/%h want %h/%b/%h", o.data, o.last, o.id, e.data, e.last, e.id);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_err_fetch();
    int fh, fa;
    exp_t e; obs_t o;
    err_q.delete();
    do_fetch(32'h3, 4'h2, 0, fh, fa);
    checks++;
    if (err_q.size() != 1 || err_q[0] != fh) begin
      errors++; $display("FAIL errfetch_pulse got %0d pulses first cyc %0d want 1 at %0d",
                         err_q.size(), (err_q.size() > 0) ? err_q[0] : -1, fh);
    end
    checks++;
    if (obs_q.size() != 4) begin errors++; $display("FAIL errfetch_count got %0d want 4", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.last !== e.last || o.id !== e.id || o.data !== e.data) begin
        errors++; $display("FAIL errfetch_beat got %h/%b/%h want %h/%b/%h", o.data, o.last, o.id, e.data, e.last, e.id);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_err_store();
    int sh, se, fh, fa;
    exp_t e; obs_t o;
    err_q.delete();
    do_store(32'h1000, 4, 32'hDEADBEEF, 32'h1, 4'hF, sh, se);
    checks++;
    if (err_q.size() != 1 || err_q[0] != sh) begin
      errors++; $display("FAIL errstore_pulse got %0d pulses want 1 at %0d", err_q.size(), sh);
    end
    checks++;
    if (se != sh + 4) begin errors++; $display("FAIL errstore_consume got cyc %0d want %0d", se, sh + 4); end
    do_fetch(32'h0, 4'h1, 0, fh, fa);
    if (obs_q.size() > 0) begin
      checks++;
      if (obs_q[0].data !== 32'hCAFE0203) begin
        errors++; $display("FAIL errstore_word0 got %h want cafe0203", obs_q[0].data);
      end
    end
    checks++;
    if (obs_q.size() != 4) begin errors++; $display("FAIL errstore_count got %0d want 4", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.last !== e.last || o.id !== e.id || (e.known && o.data !== e.data)) begin
        errors++; $display("FAIL errstore_beat got %h/%b/%h want %h/%b/%h", o.data, o.last, o.id, e.data, e.last, e.id);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_simultaneous();
    int sh, se, fh, fa;
    exp_t e; obs_t o;
    do_store(32'h80, 4, 32'h0, 32'h0, 4'hF, sh, se);
    mem_fetch_i = 1'b1;
    do_store(32'h80, 4, 32'h5A5A0000, 32'h00000011, 4'hF, sh, se);
    do_fetch(32'h80, 4'h9, 0, fh, fa);
    checks++;
    if (fh != se + 1) begin errors++; $display("FAIL simul_order fetch hs cyc %0d want %0d", fh, se + 1); end
    checks++;
    if (obs_q.size() != 4) begin errors++; $display("FAIL simul_count got %0d want 4", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.last !== e.last || o.id !== e.id || (e.known && o.data !== e.data)) begin
        errors++; $display("FAIL simul_beat got %h/%b/%h want %h/%b/%h", o.data, o.last, o.id, e.data, e.last, e.id);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_mid_reset();
    bit hs;
    int g, fh, fa;
    exp_t e; obs_t o;
    mem_fetch_i = 1'b1; mem_addr_i = 32'h0; mem_req_id_i = 4'h6;
    hs = 1'b0; g = 0;
    while (!hs && g < 100) begin
      @(negedge clock); hs = mem_accept_o;
      @(posedge clock); #1; g++;
    end
    mem_fetch_i = 1'b0; mem_ready_i = 1'b1;
    checks++;
    if (!hs) begin errors++; $display("FAIL midreset_accept_timeout got 0 want 1"); end
    repeat (2) begin @(posedge clock); #1; end
    checks++;
    if (mem_valid_o !== 1'b1) begin errors++; $display("FAIL midreset_beat2 valid got %b want 1", mem_valid_o); end
    reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if ({mem_accept_o, mem_error_o, mem_ready_o, mem_valid_o, mem_last_o, mem_resp_id_o,
         mem_rddata_o} !== 41'h0) begin
      errors++; $display("FAIL midreset_outputs got acc=%b vld=%b last=%b id=%h data=%h want all 0",
                         mem_accept_o, mem_valid_o, mem_last_o, mem_resp_id_o, mem_rddata_o);
    end
    reset = 1'b0; mem_ready_i = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (mem_accept_o !== 1'b1 || mem_valid_o !== 1'b0) begin
      errors++; $display("FAIL midreset_recover got acc=%b vld=%b want 1/0", mem_accept_o, mem_valid_o);
    end
    do_fetch(32'h0, 4'hC, 0, fh, fa);
    checks++;
    if (obs_q.size() != 4) begin errors++; $display("FAIL postreset_count got %0d want 4", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.last !== e.last || o.id !== e.id || (e.known && o.data !== e.data)) begin
        errors++; $display("FAIL postreset_beat got %h/%b/%h want %h/%b/%h", o.data, o.last, o.id, e.data, e.last, e.id);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin model[i] = 32'h0; known[i] = 1'b0; end
    test_reset();
    test_aligned();
    test_mask();
    test_backpressure();
    test_wrap();
    test_err_fetch();
    test_err_store();
    test_simultaneous();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_bram_backend.md
Name: ddr3_bram_backend

Overview:
- Synthesisable on-chip memory backend that sits on the controller-side memory port of ddr3_axi_ctrl in place of the DDR3 PHY path.
- Used for SDRAM-less builds and as the reference slave in controller regressions.
- Generalises the bench-only fake SDRAM in four ways: parametrised width, depth, burst length and ID width; byte-masked writes; a read skid buffer that tolerates backpressure; in-band error reporting instead of simulation abort.

Parameters:
- WIDTH, 32, data bus width in bits (multiple of 8).
- MASKS, WIDTH/8, byte-lane mask width.
- ADDRS, 32, byte address width.
- REQID, 4, request/response ID width.
- MBITS, 10, log2 of memory depth in WIDTH-bit words.
- BURST, 4, beats returned per fetch (power of two, 2..16).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- mem_store_i  in  1  write request.
- mem_fetch_i  in  1  read request.
- mem_accept_o  out  1  request accepted when (store|fetch) & accept.
- mem_error_o  out  1  one-cycle error pulse.
- mem_req_id_i  in  REQID  request ID.
- mem_addr_i  in  ADDRS  byte address of the request.
- mem_valid_i  in  1  write beat valid.
- mem_ready_o  out  1  write beat ready.
- mem_last_i  in  1  final write beat.
- mem_wrmask_i  in  MASKS  byte enables.
- mem_wrdata_i  in  WIDTH  write data.
- mem_valid_o  out  1  read beat valid.
- mem_ready_i  in  1  read beat ready.
- mem_last_o  out  1  final read beat.
- mem_resp_id_o  out  REQID  ID of the read response.
- mem_rddata_o  out  WIDTH  read data.

Behaviour:
- Clocking and reset: reset is synchronous, active-high; clock is clock.
- Reset values: all outputs 0, state IDLE. Memory contents are not reset.
- Reset mid-operation: reset aborts any burst. In-flight beats are dropped and no error is raised.
- States: IDLE, WRITE, READ.
  - mem_accept_o is registered and is 1 only in IDLE.
  - It rises the cycle after reset deasserts.
- Request priority: if store and fetch are both asserted, store wins; fetch stays pending.
- Word index: widx = mem_addr_i[MBITS+log2(MASKS)-1 : log2(MASKS)].
- Error condition: address low bits nonzero (misaligned), or any address bit above the word-index field set (out of range).
  - On error, mem_error_o pulses in the cycle after the accept handshake.
  - The request is still fully serviced on the handshake side, so the requester never hangs.
- IDLE -> WRITE on an accepted store. In WRITE:
  - mem_ready_o=1.
  - Each valid&ready beat writes the lanes whose mask bit is 1 at waddr, then waddr <= waddr+1 modulo 2^MBITS.
  - On an errored store, beats are consumed and discarded.
  - The beat carrying mem_last_i returns to IDLE. Write length is set by last, not by BURST.
- IDLE -> READ on an accepted fetch. ID is latched to mem_resp_id_o. In READ:
  - The array is synchronous-read with 1-cycle latency.
  - The reader issues a read only when skid occupancy plus in-flight reads < 2.
  - The 2-entry skid buffer drives mem_valid_o/mem_rddata_o.
  - Read address increments modulo 2^MBITS (linear wrap, not a wrapping burst).
  - An errored fetch returns BURST beats of all-zero data.
  - mem_last_o is set on the BURST-th beat. The last beat's handshake returns to IDLE.
- Read latency (fetch accepted at edge T, mem_ready_i held 1):
  - beats valid on cycles T+2 .. T+BURST+1, last at T+BURST+1;
  - mem_accept_o high again at T+BURST+2.
- Backpressure: mem_valid_o and mem_rddata_o are held stable while mem_ready_i=0. No beat is lost or duplicated.
- Write visibility: a write beat is visible to any fetch accepted on a later cycle.
- Payload stability: mem_resp_id_o and mem_rddata_o are stable while valid&~ready.

Test Plan:
- Aligned store: addr 0x0, 4 beats 0x11111111..0x44444444, mask 0xF; then fetch addr 0x0, id 5, ready=1 -> beats on T+2..T+5 match, last on beat 4, mem_resp_id_o=5, mem_error_o never set.
- Byte masking: store 0xAABBCCDD with mask 0x5 over existing 0x00000000 at addr 0x40, then fetch -> 0x00BB00DD.
- Backpressure: fetch with mem_ready_i toggled 1,0,0,1,0,1... -> exactly BURST beats, in address order, each held stable while stalled, last only on the final beat.
- Depth wrap: store 4 beats at word 2^MBITS-2 (byte 0xFF8 for defaults) -> words 1022, 1023, 0, 1 written; readback at 0xFF8 wraps identically.
- Errors:
  - Fetch at 0x3 -> mem_error_o pulse at T+1; 4 zero beats with last.
  - Store at 0x1000 -> pulse; beats accepted and discarded; word 0 unchanged.
- Simultaneous requests and mid-burst reset:
  - store and fetch asserted together -> store serviced first, fetch accepted after store last.
  - Reset asserted on read beat 2 -> all outputs 0 next cycle; accept=1 the cycle after reset drops.
